// File: rtl/mult_exhaustive_checker.sv
// Exhaustive checker for a multiplier candidate: sweeps every (A, B) pair, compares the
// candidate's product with the exact product and records the error count and first failure.
// Optional: `define MULT_CHECK_HAMMING_EN adds bit_err_count (accumulated popcount of P ^ expected).
module mult_exhaustive_checker #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned LAT   = 0,
  parameter int unsigned CNT_W = 2*WIDTH+1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [WIDTH-1:0]       mul_a,
  output logic [WIDTH-1:0]       mul_b,
  input  logic [2*WIDTH-1:0]     mul_p,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [CNT_W-1:0]       err_count,
  output logic [WIDTH-1:0]       first_fail_a,
  output logic [WIDTH-1:0]       first_fail_b,
  output logic [2*WIDTH-1:0]     first_fail_p,
  output logic                   first_fail_vld
`ifdef MULT_CHECK_HAMMING_EN
  ,
  output logic [2*WIDTH+CNT_W-1:0] bit_err_count
`endif
);

  localparam int unsigned PW        = 2*WIDTH;
  localparam int unsigned WAIT_W    = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int unsigned WAIT_LAST = (LAT > 0) ? LAT - 1 : 0;

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, FIN} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     idx_q, idx_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [WIDTH-1:0]  ffa_q, ffa_d;
  logic [WIDTH-1:0]  ffb_q, ffb_d;
  logic [PW-1:0]     ffp_q, ffp_d;
  logic              ffv_q, ffv_d;

  logic [PW-1:0]     expected_c;
  logic              mismatch_c;

  // Operands come straight from the registered vector index.
  assign mul_a = idx_q[WIDTH-1:0];
  assign mul_b = idx_q[PW-1:WIDTH];

  assign expected_c = PW'(mul_a) * PW'(mul_b);
  assign mismatch_c = (mul_p != expected_c);

`ifdef MULT_CHECK_HAMMING_EN
  localparam int unsigned HW = 2*WIDTH+CNT_W;
  logic [HW-1:0] ham_q, ham_d;
  logic [PW-1:0] diff_c;
  logic [HW-1:0] pop_c;

  assign diff_c = mul_p ^ expected_c;

  always_comb begin
    pop_c = '0;
    for (int k = 0; k < PW; k++) begin
      pop_c = pop_c + HW'(diff_c[k]);
    end
  end

  assign bit_err_count = ham_q;
`endif

  // Next-state and register-update logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    ffa_d   = ffa_q;
    ffb_d   = ffb_q;
    ffp_d   = ffp_q;
    ffv_d   = ffv_q;
`ifdef MULT_CHECK_HAMMING_EN
    ham_d   = ham_q;
`endif

    case (state_q)
      IDLE, FIN: begin
        if (start) begin
          idx_d  = '0;
          wcnt_d = '0;
          busy_d = 1'b1;
          done_d = 1'b0;
          err_d  = '0;
          ffa_d  = '0;
          ffb_d  = '0;
          ffp_d  = '0;
          ffv_d  = 1'b0;
`ifdef MULT_CHECK_HAMMING_EN
          ham_d  = '0;
`endif
          if (LAT == 0) state_d = CHECK;
          else          state_d = APPLY;
        end
      end
      APPLY: begin
        if (wcnt_q == WAIT_W'(WAIT_LAST)) begin
          state_d = CHECK;
        end else begin
          wcnt_d = wcnt_q + WAIT_W'(1);
        end
      end
      CHECK: begin
        if (mismatch_c) begin
          if (err_q != '1) err_d = err_q + CNT_W'(1);
          if (!ffv_q) begin
            ffa_d = mul_a;
            ffb_d = mul_b;
            ffp_d = mul_p;
            ffv_d = 1'b1;
          end
        end
`ifdef MULT_CHECK_HAMMING_EN
        ham_d = ham_q + pop_c;
`endif
        // Terminal on the last index itself, so the index never wraps.
        if (idx_q == '1) begin
          state_d = FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          idx_d  = idx_q + PW'(1);
          wcnt_d = '0;
          if (LAT == 0) state_d = CHECK;
          else          state_d = APPLY;
        end
      end
      default: state_d = IDLE;
    endcase

    pass_d = done_d && (err_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ffa_q   <= '0;
      ffb_q   <= '0;
      ffp_q   <= '0;
      ffv_q   <= 1'b0;
`ifdef MULT_CHECK_HAMMING_EN
      ham_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ffa_q   <= ffa_d;
      ffb_q   <= ffb_d;
      ffp_q   <= ffp_d;
      ffv_q   <= ffv_d;
`ifdef MULT_CHECK_HAMMING_EN
      ham_q   <= ham_d;
`endif
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_a   = ffa_q;
  assign first_fail_b   = ffb_q;
  assign first_fail_p   = ffp_q;
  assign first_fail_vld = ffv_q;

endmodule

// File: tb/tb_mult_exhaustive_checker.sv
// Bench for mult_exhaustive_checker: a combinational (LAT=0) and a 2-stage (LAT=2) instance
// driven by behavioural candidates; a reference model queues the expected run summary.
module tb_mult_exhaustive_checker;

  localparam int unsigned W  = 2;
  localparam int unsigned CW = 2*W+1;

  typedef struct {
    int         errs;
    int         bits;
    int         cycles;
    logic       pass;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [3:0] fp;
    logic       fv;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_drv;
  logic       sel;
  logic [1:0] mode;

  always #5 clk = ~clk;

  // Candidate behaviours: 0 ideal, 1 stuck-at-zero, 2 LSB flipped.
  function automatic logic [3:0] cand(input logic [1:0] m, input logic [1:0] a, input logic [1:0] b);
    logic [3:0] ideal;
    ideal = {2'b00, a} * {2'b00, b};
    case (m)
      2'd1:    return 4'd0;
      2'd2:    return ideal ^ 4'd1;
      default: return ideal;
    endcase
  endfunction

  function automatic exp_t model(input logic [1:0] m, input int lat);
    exp_t e;
    logic [3:0] iv, p, ex;
    logic [1:0] a, b;
    e.errs = 0; e.bits = 0; e.fv = 1'b0; e.fa = '0; e.fb = '0; e.fp = '0;
    for (int i = 0; i < 16; i++) begin
      iv = 4'(i);
      a  = iv[1:0];
      b  = iv[3:2];
      p  = cand(m, a, b);
      ex = 4'(int'(a) * int'(b));
      if (p !== ex) begin
        e.errs++;
        if (!e.fv) begin
          e.fv = 1'b1; e.fa = a; e.fb = b; e.fp = p;
        end
      end
      e.bits += $countones(p ^ ex);
    end
    e.pass   = (e.errs == 0);
    e.cycles = 16 * (lat + 1);
    return e;
  endfunction

  // DUT0: LAT=0
  logic [1:0] a0, b0, ffa0, ffb0;
  logic [3:0] p0, ffp0;
  logic       busy0, done0, pass0, ffv0;
  logic [CW-1:0] err0;
  logic       start0;
  // DUT2: LAT=2
  logic [1:0] a2, b2, ffa2, ffb2;
  logic [3:0] p2, ffp2, s1, s2;
  logic       busy2, done2, pass2, ffv2;
  logic [CW-1:0] err2;
  logic       start2;
`ifdef MULT_CHECK_HAMMING_EN
  logic [2*W+CW-1:0] bits0, bits2;
`endif

  assign start0 = start_drv && !sel;
  assign start2 = start_drv && sel;
  assign p0     = cand(mode, a0, b0);
  assign p2     = s2;

  always_ff @(posedge clk) begin
    s1 <= cand(mode, a2, b2);
    s2 <= s1;
  end

  mult_exhaustive_checker #(.WIDTH(W), .LAT(0), .CNT_W(CW)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .mul_a(a0), .mul_b(b0), .mul_p(p0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_fail_a(ffa0), .first_fail_b(ffb0), .first_fail_p(ffp0), .first_fail_vld(ffv0)
`ifdef MULT_CHECK_HAMMING_EN
    , .bit_err_count(bits0)
`endif
  );

  mult_exhaustive_checker #(.WIDTH(W), .LAT(2), .CNT_W(CW)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .mul_a(a2), .mul_b(b2), .mul_p(p2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_fail_a(ffa2), .first_fail_b(ffb2), .first_fail_p(ffp2), .first_fail_vld(ffv2)
`ifdef MULT_CHECK_HAMMING_EN
    , .bit_err_count(bits2)
`endif
  );

  // Observed view of whichever instance is selected.
  logic [1:0]    o_a, o_b, o_ffa, o_ffb;
  logic [3:0]    o_ffp;
  logic          o_busy, o_done, o_pass, o_ffv;
  logic [CW-1:0] o_err;
  assign o_a    = sel ? a2    : a0;
  assign o_b    = sel ? b2    : b0;
  assign o_ffa  = sel ? ffa2  : ffa0;
  assign o_ffb  = sel ? ffb2  : ffb0;
  assign o_ffp  = sel ? ffp2  : ffp0;
  assign o_busy = sel ? busy2 : busy0;
  assign o_done = sel ? done2 : done0;
  assign o_pass = sel ? pass2 : pass0;
  assign o_ffv  = sel ? ffv2  : ffv0;
  assign o_err  = sel ? err2  : err0;
`ifdef MULT_CHECK_HAMMING_EN
  logic [2*W+CW-1:0] o_bits;
  assign o_bits = sel ? bits2 : bits0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_a"},    32'(o_a),    0);
    chk({tag, "_b"},    32'(o_b),    0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_done"}, 32'(o_done), 0);
    chk({tag, "_pass"}, 32'(o_pass), 0);
    chk({tag, "_err"},  32'(o_err),  0);
    chk({tag, "_ffa"},  32'(o_ffa),  0);
    chk({tag, "_ffb"},  32'(o_ffb),  0);
    chk({tag, "_ffp"},  32'(o_ffp),  0);
    chk({tag, "_ffv"},  32'(o_ffv),  0);
`ifdef MULT_CHECK_HAMMING_EN
    chk({tag, "_bits"}, 32'(o_bits), 0);
`endif
  endtask

  // Full run: push the model's expectation, sweep, then pop and compare at done.
  task automatic run(input logic use2, input logic [1:0] m, input logic inject, input string tag);
    exp_t e;
    int   n;
    int   lat;
    int   vi;
    lat  = use2 ? 2 : 0;
    sel  = use2;
    mode = m;
    q.push_back(model(m, lat));
    @(negedge clk);
    start_drv = 1'b1;
    @(posedge clk); #1;
    start_drv = 1'b0;
    chk({tag, "_busy_start"}, 32'(o_busy), 1);
    chk({tag, "_done_start"}, 32'(o_done), 0);
    n = 0;
    while (!o_done && n < 400) begin
      if (n < 16 * (lat + 1)) begin
        vi = n / (lat + 1);
        chk({tag, "_op_a"}, 32'(o_a), 32'(vi % 4));
        chk({tag, "_op_b"}, 32'(o_b), 32'(vi / 4));
      end
      if (inject && n == 3) start_drv = 1'b1;
      @(posedge clk); #1;
      start_drv = 1'b0;
      n++;
    end
    e = q.pop_front();
    chk({tag, "_cycles"}, 32'(n),      32'(e.cycles));
    chk({tag, "_done"},   32'(o_done), 1);
    chk({tag, "_busy"},   32'(o_busy), 0);
    chk({tag, "_pass"},   32'(o_pass), 32'(e.pass));
    chk({tag, "_err"},    32'(o_err),  32'(e.errs));
    chk({tag, "_ffv"},    32'(o_ffv),  32'(e.fv));
    chk({tag, "_ffa"},    32'(o_ffa),  32'(e.fa));
    chk({tag, "_ffb"},    32'(o_ffb),  32'(e.fb));
    chk({tag, "_ffp"},    32'(o_ffp),  32'(e.fp));
`ifdef MULT_CHECK_HAMMING_EN
    chk({tag, "_bits"},   32'(o_bits), 32'(e.bits));
`endif
    @(posedge clk); #1;
    chk({tag, "_done_hold"}, 32'(o_done), 1);
  endtask

  initial begin
    rst       = 1'b1;
    start_drv = 1'b0;
    sel       = 1'b0;
    mode      = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    sel = 1'b0; chk_cleared("reset0");
    sel = 1'b1; chk_cleared("reset2");
    @(negedge clk);
    rst = 1'b0;

    run(1'b0, 2'd0, 1'b0, "ideal0");
    run(1'b0, 2'd1, 1'b0, "stuck0");
    run(1'b0, 2'd2, 1'b0, "xor1");
    run(1'b1, 2'd0, 1'b0, "ideal_lat2");
    run(1'b0, 2'd0, 1'b1, "start_busy");

    // Abort during vector 7, then a clean restart.
    sel  = 1'b0;
    mode = 2'd0;
    @(negedge clk);
    start_drv = 1'b1;
    @(posedge clk); #1;
    start_drv = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    chk("abort_at_vec7_a", 32'(o_a), 3);
    chk("abort_at_vec7_b", 32'(o_b), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_cleared("abort");
    run(1'b0, 2'd0, 1'b0, "restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_exhaustive_checker.md
Name: mult_exhaustive_checker

Overview:
- Test-sequencer stage that wraps a generated combinational or pipelined multiplier candidate.
- Upstream role: drives every operand pair (A, B) of width WIDTH into the candidate.
- Downstream role: consumes the candidate's product P and compares it with the exact product.
- Reports mismatch count and first failing vector. Used to score and qualify uncorrected candidates before they enter the design pool.

Parameters:
- WIDTH, 2, operand width of the candidate multiplier; product is 2*WIDTH bits.
- LAT, 0, candidate latency in cycles (0 = combinational).
- CNT_W, 2*WIDTH+1, width of the error counters; must hold 4^WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins an exhaustive run.
- mul_a  out  WIDTH  operand A to the candidate.
- mul_b  out  WIDTH  operand B to the candidate.
- mul_p  in  2*WIDTH  product from the candidate.
- busy  out  1  high while a run is in progress.
- done  out  1  high once a run has completed; held until the next accepted start or rst.
- pass  out  1  equals done && (err_count == 0).
- err_count  out  CNT_W  number of mismatching vectors.
- first_fail_a  out  WIDTH  A of the first mismatch.
- first_fail_b  out  WIDTH  B of the first mismatch.
- first_fail_p  out  2*WIDTH  mul_p captured at the first mismatch.
- first_fail_vld  out  1  high once any mismatch has been captured.

Behaviour:
- Reset: every output register is cleared to 0 (mul_a, mul_b, busy, done, pass, err_count, first_fail_*, first_fail_vld). FSM returns to IDLE.
- FSM states: IDLE, APPLY, CHECK, FIN.
- Vector index i (2*WIDTH bits) determines the operands: mul_a = i[WIDTH-1:0], mul_b = i[2*WIDTH-1:WIDTH]. Operands are registered and held stable for the whole vector.
- IDLE or FIN + start: set i=0, clear err_count and first_fail_*, clear done, set busy=1, go to APPLY.
- APPLY: hold the operands for LAT cycles via the wait counter. When LAT=0, go directly to CHECK on the next cycle.
- CHECK (one cycle): sample mul_p. In total, sampling happens LAT+1 cycles after the operands first appear.
  - Expected product = mul_a * mul_b, unsigned, full 2*WIDTH bits, with no truncation.
  - On mismatch: err_count++ (saturating at all-ones). If first_fail_vld is 0, capture a, b, mul_p and set first_fail_vld.
  - If i is all-ones, go to FIN. Otherwise i++ and return to APPLY, with the new operands driven in the same edge.
- FIN: busy=0, done=1. pass becomes valid in the same cycle as done.
- Cycle budget: 4^WIDTH*(LAT+1) cycles from start acceptance to the last CHECK. done rises on the following edge.
- start while busy is ignored, with no restart and no state change.
- rst mid-run aborts immediately to IDLE with all outputs cleared. No partial result is retained.
- Index wrap: i never wraps during a run. The terminal condition is detected on i all-ones, not on i overflow.
- Wide-case check: for WIDTH=8 the run is 65536 vectors. err_count is 17 bits by default.

Optional Feature:
- Macro: MULT_CHECK_HAMMING_EN.
- Defined: adds output bit_err_count (width 2*WIDTH+CNT_W). In each CHECK it accumulates popcount(mul_p XOR expected). It is cleared on start and on rst. The RL flow uses it as a graded reward in addition to pass/fail.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- WIDTH=2, LAT=0, ideal model P=A*B, start pulse:
  - done rises exactly 16 cycles after start is accepted (i.e. on the edge after the 16th CHECK).
  - err_count=0, pass=1, first_fail_vld=0.
- WIDTH=2, LAT=0, stuck-at-zero model P=0:
  - err_count=9, pass=0.
  - first_fail a=1, b=1, p=0 (this is vector i=5).
  - With MULT_CHECK_HAMMING_EN: bit_err_count=14.
- WIDTH=2, LAT=0, model P=(A*B)^1:
  - err_count=16.
  - first_fail a=0, b=0, p=1.
  - bit_err_count=16.
- WIDTH=2, LAT=2, 2-stage pipelined ideal model:
  - done after 48 cycles, err_count=0.
  - Operands are stable for 3 cycles per vector.
- Abort and restart, ideal model: assert rst during vector i=7, then pulse start.
  - All outputs are 0 after rst.
  - The full 16-vector run completes with pass=1.
- Start while busy, ideal model: pulse start again at vector i=3.
  - The pulse is ignored.
  - done arrives on the original 16-cycle schedule.
